counter_ctrl: RTL
=================

# counter_ctrl

Command scheduler for one 8-bit event counter in the counters sample design. Three requesters share the counter's single update port: host up-pulses, host down-pulses and a prescaled autocount tick, all on sys_clk. Requests are latched, arbitrated round-robin and applied at most one per cycle. A host clear has absolute priority. Wrap, zero and overrun events are produced for the trigger-out and wire-out endpoints.

## Interface
Parameters:
- DIV_LOAD, 24'h100000, prescaler reload value; autocount tick period is DIV_LOAD+1 cycles.
- CNT_W, 8, counter width.

Ports:
- sys_clk  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high reset.
- clear_trig  in  1  one-cycle pulse from the host; clears the counter and flushes requests.
- up_trig  in  1  one-cycle pulse; request increment.
- down_trig  in  1  one-cycle pulse; request decrement.
- autocount_en  in  1  level; enables tick requests.
- enable  in  1  level; 0 freezes grants (clear is still served).
- count  out  CNT_W  counter value.
- pending  out  3  latched requests {auto, down, up}.
- wrap_trig  out  1  one-cycle pulse on wrap (or on a saturated hit, see Configuration).
- zero_trig  out  1  one-cycle pulse when count becomes 0 from a non-zero value.
- overrun  out  1  sticky flag: a request was dropped.

## Operation
- Prescaler: div decrements every cycle. When div==0 it reloads DIV_LOAD and raises an internal tick for 1 cycle. The prescaler free-runs regardless of enable and autocount_en.
- Request latch, per source (UP, DOWN, AUTO):
  - The source pulse sets its pending bit at the next edge. The AUTO pulse is tick & autocount_en.
  - A granted bit clears at the edge of its grant.
  - A pulse arriving in the same cycle as that source's grant re-sets the bit; it is accepted.
  - A pulse arriving while the bit is set and not granted is dropped and sets overrun.
- Arbiter: combinational from pending and the rr pointer.
  - Order is UP → DOWN → AUTO.
  - The pointer names the highest-priority source. After a grant it moves to the source after the granted one.
  - No grant when enable=0 or clr_pend=1.
- Clear:
  - clear_trig sets clr_pend.
  - At the next edge: count=0, all pending bits=0 (pulses in that same cycle are discarded, no overrun), overrun=0, clr_pend=0.
  - The rr pointer is kept.
  - If count was non-zero, zero_trig pulses.
- Apply: a grant of UP or AUTO does count+1; DOWN does count−1. Arithmetic is mod 2^CNT_W.
  - Increment FF→00 and decrement 00→FF pulse wrap_trig.
  - Any update landing on 0 from non-zero pulses zero_trig.

## Timing
- Reset values: count=0, pending=0, clr_pend=0, overrun=0, wrap_trig=0, zero_trig=0, rr pointer=UP, div=DIV_LOAD.
- Latency, uncontended: pulse in cycle c → pending visible c+1 → count updated at end of c+1, visible c+2.
- wrap_trig and zero_trig are registered at the same edge as the count update that causes them.
- Throughput: one update per cycle. Three simultaneous pulses complete in 3 consecutive cycles.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight requests are lost.
- enable low: pending bits hold, new pulses still latch or overrun, count holds.

## Configuration
- COUNTER_CTRL_SATURATE_EN defined:
  - Increment at all-ones and decrement at 0 leave count unchanged.
  - The grant is still consumed.
  - wrap_trig pulses to flag the saturated hit.
- Undefined: modular wrap as in Operation.

## Test plan
- Reset, then up_trig in cycle 5 → count=0x01 visible in cycle 7; pending[0]=1 in cycle 6 only.
- up, down and auto pulses in the same cycle, rr=UP → grants UP, DOWN, AUTO on consecutive cycles; count 0→1→0→1; zero_trig once; rr ends at UP.
- count=0xFF, up_trig → count=0x00, wrap_trig=1 and zero_trig=1 in the same cycle. Under SATURATE_EN: count stays 0xFF, wrap_trig=1, zero_trig=0.
- enable=0, up_trig twice 3 cycles apart → pending[0]=1, overrun=1, count unchanged; set enable=1 → count+1 exactly once.
- DIV_LOAD=3, autocount_en=1 for 40 cycles → 10 increments at 4-cycle spacing.
- count=0x05 with down pending, clear_trig → next edge count=0, pending=0, overrun=0, zero_trig=1; down_trig in the clear cycle is ignored; asserting reset mid-run zeros everything asynchronously.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: latches up/down/autocount requests, grants them round-robin one per cycle
// and applies them to the counter. Define COUNTER_CTRL_SATURATE_EN to saturate instead of wrap.
module counter_ctrl #(
   parameter logic [23:0] DIV_LOAD = 24'h100000,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             clear_trig,
   input  logic             up_trig,
   input  logic             down_trig,
   input  logic             autocount_en,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic [2:0]       pending,
   output logic             wrap_trig,
   output logic             zero_trig,
   output logic             overrun
);
   typedef enum logic [1:0] {RR_UP = 2'd0, RR_DOWN = 2'd1, RR_AUTO = 2'd2} rr_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [23:0]      div_q, div_d;
   logic             tick;
   logic [2:0]       req, grant;
   logic [2:0]       pend_q, pend_d;
   rr_e              rr_q, rr_d;
   logic             clr_pend_q, clr_pend_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             zero_q, zero_d;
   logic             ovr_q, ovr_d;

   // Free-running prescaler, independent of enable/autocount_en.
   assign tick  = (div_q == 24'd0);
   assign div_d = tick ? DIV_LOAD : div_q - 24'd1;
   assign req   = {tick & autocount_en, down_trig, up_trig};

   // Round-robin arbiter: rr_q names the source that is checked first.
   always_comb begin
      grant = 3'b000;
      rr_d  = rr_q;
      if (enable && !clr_pend_q) begin
         case (rr_q)
            RR_DOWN: begin
               if      (pend_q[1]) grant = 3'b010;
               else if (pend_q[2]) grant = 3'b100;
               else if (pend_q[0]) grant = 3'b001;
            end
            RR_AUTO: begin
               if      (pend_q[2]) grant = 3'b100;
               else if (pend_q[0]) grant = 3'b001;
               else if (pend_q[1]) grant = 3'b010;
            end
            default: begin
               if      (pend_q[0]) grant = 3'b001;
               else if (pend_q[1]) grant = 3'b010;
               else if (pend_q[2]) grant = 3'b100;
            end
         endcase
      end
      if      (grant[0]) rr_d = RR_DOWN;
      else if (grant[1]) rr_d = RR_AUTO;
      else if (grant[2]) rr_d = RR_UP;
   end

   always_comb begin
      count_d    = count_q;
      pend_d     = pend_q;
      ovr_d      = ovr_q;
      wrap_d     = 1'b0;
      zero_d     = 1'b0;
      clr_pend_d = 1'b0;
      if (clr_pend_q) begin
         // Clear flushes everything, including pulses arriving this cycle.
         count_d = '0;
         pend_d  = 3'b000;
         ovr_d   = 1'b0;
         zero_d  = (count_q != '0);
      end else begin
         clr_pend_d = clear_trig;
         ovr_d      = ovr_q | (|(req & pend_q & ~grant));
         pend_d     = (pend_q & ~grant) | req;
         if (grant[1]) begin
            if (count_q == '0) begin
               wrap_d = 1'b1;
`ifdef COUNTER_CTRL_SATURATE_EN
               count_d = count_q;
`else
               count_d = CNT_MAX;
`endif
            end else begin
               count_d = count_q - CNT_ONE;
            end
         end else if (grant[0] || grant[2]) begin
            if (count_q == CNT_MAX) begin
               wrap_d = 1'b1;
`ifdef COUNTER_CTRL_SATURATE_EN
               count_d = count_q;
`else
               count_d = '0;
`endif
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         zero_d = (count_d == '0) && (count_q != '0);
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         div_q      <= DIV_LOAD;
         pend_q     <= 3'b000;
         rr_q       <= RR_UP;
         clr_pend_q <= 1'b0;
         count_q    <= '0;
         wrap_q     <= 1'b0;
         zero_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         div_q      <= div_d;
         pend_q     <= pend_d;
         rr_q       <= rr_d;
         clr_pend_q <= clr_pend_d;
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         zero_q     <= zero_d;
         ovr_q      <= ovr_d;
      end
   end

   assign count     = count_q;
   assign pending   = pend_q;
   assign wrap_trig = wrap_q;
   assign zero_trig = zero_q;
   assign overrun   = ovr_q;
endmodule
